// File: rtl/fc_ctrl.sv
// Sequencer for the FC classifier stage: clears the FC datapath, streams P feature
// positions with an exactly-P-beat clock enable, then waits for and holds the class result.
module fc_ctrl #(
    parameter int I_BW      = 32,
    parameter int CI        = 3,
    parameter int IF_SIZE   = 4,
    parameter int ADDR_BW   = 4,
    parameter int TO_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 buf_rd_en,
    output logic [ADDR_BW-1:0]   buf_rd_addr,
    input  logic [CI*I_BW-1:0]   buf_rd_data,
    output logic                 fc_rst,
    output logic                 fc_ce,
    output logic [CI*I_BW-1:0]   fc_data,
    input  logic                 fc_done,
    input  logic [3:0]           fc_class,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_class,
    output logic                 timeout_err
);
    localparam int P    = IF_SIZE * IF_SIZE;
    localparam int TO_W = $clog2(TO_CYCLES) + 1;
    localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(P - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WAIT, S_OUT
    } state_t;

    state_t              r_state, w_next;
    logic [ADDR_BW-1:0]  r_addr;
    logic [TO_W-1:0]     r_to_cnt;
    logic [TO_W-1:0]     w_to_inc;
    logic                r_ce;
    logic [3:0]          r_res_class;
    logic                r_timeout_err;
    logic                w_start_ok;
    logic                w_feed_last;
    logic                w_done_hit;
    logic                w_to_hit;

    assign w_to_inc    = r_to_cnt + TO_W'(1);
    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_feed_last = (r_state == S_FEED) && (r_addr == LAST_ADDR);
    assign w_done_hit  = (r_state == S_WAIT) && fc_done;
    // The timeout fires on the edge where the counter would reach TO_CYCLES-1.
    assign w_to_hit    = (r_state == S_WAIT) && !fc_done && (w_to_inc == TO_LAST);

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) r_state <= S_IDLE;
        else               r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_ok)  w_next = S_CLEAR;
            S_CLEAR:                  w_next = S_FEED;
            S_FEED:  if (w_feed_last) w_next = S_DRAIN;
            S_DRAIN:                  w_next = S_WAIT;
            S_WAIT: begin
                if (w_done_hit)       w_next = S_OUT;
                else if (w_to_hit)    w_next = S_IDLE;
            end
            S_OUT:   if (res_ready)   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        fc_rst      = (r_state == S_CLEAR);
        buf_rd_en   = (r_state == S_FEED);
        buf_rd_addr = (r_state == S_FEED) ? r_addr : '0;
        res_valid   = (r_state == S_OUT);
    end

    // fc_ce trails the read strobe by the buffer's one-cycle read latency, so it is
    // high for exactly P cycles and lines up with buf_rd_data.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_ce     <= 1'b0;
            r_addr   <= '0;
            r_to_cnt <= '0;
        end else begin
            r_ce <= (r_state == S_FEED);
            if (r_state == S_CLEAR)
                r_addr <= '0;
            else if ((r_state == S_FEED) && (r_addr != LAST_ADDR))
                r_addr <= r_addr + ADDR_BW'(1);
            if (r_state == S_DRAIN)
                r_to_cnt <= '0;
            else if (r_state == S_WAIT)
                r_to_cnt <= w_to_inc;
        end
    end

    // Result and error stay visible after returning to IDLE until the next accepted start.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_res_class   <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_start_ok) begin
            r_res_class   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_done_hit) r_res_class   <= fc_class;
            if (w_to_hit)   r_timeout_err <= 1'b1;
        end
    end

    assign fc_ce       = r_ce;
    assign fc_data     = r_ce ? buf_rd_data : '0;
    assign res_class   = r_res_class;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/fc_ctrl.md
# fc_ctrl

Sequencer for the fully-connected classifier stage. On a start pulse it clears the FC datapath and streams the pooled feature map out of the feature buffer, one spatial position (all CI channels) per cycle. It then gates the FC clock-enable so that exactly IF_SIZE*IF_SIZE beats are accumulated, waits for the FC done pulse, and holds the 4-bit class result for a downstream valid/ready consumer. The block sits between the pool-2 feature buffer and the fc datapath, and owns that datapath's `rst` and `ce`.

## Interface
- I_BW, 32, width of one channel word
- CI, 3, channels per spatial position
- IF_SIZE, 4, feature map side; P = IF_SIZE*IF_SIZE beats per inference
- ADDR_BW, 4, buffer address width; requires 2^ADDR_BW >= P
- TO_CYCLES, 64, max cycles to wait for fc_done after the last beat

Ports (clock and reset first):
- clk  in  1  single clock; all logic on the rising edge
- global_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run one inference; only accepted in IDLE
- busy  out  1  high whenever state != IDLE
- buf_rd_en  out  1  feature buffer read strobe
- buf_rd_addr  out  ADDR_BW  spatial position index, 0..P-1
- buf_rd_data  in  CI*I_BW  buffer read data, valid exactly 1 cycle after buf_rd_en
- fc_rst  out  1  synchronous clear to the FC datapath
- fc_ce  out  1  FC accumulate enable
- fc_data  out  CI*I_BW  equals buf_rd_data when fc_ce=1, otherwise 0
- fc_done  in  1  one-cycle FC completion pulse
- fc_class  in  4  FC argmax result, valid in the fc_done cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_class  out  4  captured class index
- timeout_err  out  1  sticky; fc_done was not seen within TO_CYCLES

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, WAIT_DONE, OUT.
- **IDLE**
  - start=1 → CLEAR.
  - Clears timeout_err and res_class.
- **CLEAR**
  - fc_rst=1 for exactly one cycle.
  - Loads address counter to 0.
  - → FEED.
- **FEED**
  - buf_rd_en=1; buf_rd_addr = counter; counter increments each cycle.
  - After addr P-1 is issued → DRAIN.
  - There is no stall; the buffer is full before start is issued.
- **fc_ce generation**
  - fc_ce is buf_rd_en delayed by one register stage.
  - fc_ce is high for exactly P consecutive cycles per inference, never P±1. The FC datapath starts its bias/ReLU stage only when ce falls with its count equal to P.
- **DRAIN**
  - One cycle covering the last fc_ce beat.
  - → WAIT_DONE with the timeout counter cleared.
- **WAIT_DONE**
  - fc_ce=0.
  - fc_done=1 → capture fc_class into res_class, set res_valid → OUT.
  - Timeout counter reaches TO_CYCLES-1 without fc_done → set timeout_err → IDLE; res_valid stays 0.
- **OUT**
  - res_valid=1 and res_class held stable until res_ready=1.
  - Handshake completes on the cycle with res_valid & res_ready → IDLE.
  - res_valid falls on the next edge.
- **Ignored inputs**
  - fc_done outside WAIT_DONE: no effect.
  - start outside IDLE: no effect and not queued.
- **Reset**
  - Asynchronous assertion at any time, including mid-FEED, forces IDLE.
  - All outputs go to 0: busy, buf_rd_en, buf_rd_addr, fc_rst, fc_ce, res_valid, res_class, timeout_err.
  - fc_data = 0.
- **Counter widths**
  - Address counter is ADDR_BW bits and does not wrap within a run.
  - Timeout counter is clog2(TO_CYCLES)+1 bits.

## Timing
- start sampled at edge 0 → fc_rst high in cycle 1.
- buf_rd_en in cycles 2..P+1 with addr 0..P-1.
- fc_ce in cycles 3..P+2.
- WAIT_DONE from cycle P+3.
- fc_done in cycle D → res_valid from D+1.
- With res_ready held high, busy falls at D+2 and the next start is accepted at D+2.
- Back-to-back inferences: minimum start-to-start spacing is D+2 cycles.
- A start coincident with the OUT-completion cycle is ignored (state is still OUT).

## Test plan
- **Nominal run**, P=16, FC model returns class 7 with done 8 cycles after fc_ce falls:
  - fc_rst pulses once.
  - Addr 0..15 in order.
  - fc_ce high exactly 16 cycles and aligned with data.
  - res_class=7, res_valid at D+1, timeout_err=0.
- **Backpressure**: res_ready held low 10 cycles after res_valid:
  - res_valid and res_class stable for all 10 cycles.
  - A start pulse during OUT is ignored.
  - Accepted on the first ready cycle; busy falls the next cycle.
- **Timeout**: FC model never pulses done, TO_CYCLES=64:
  - timeout_err=1 at cycle P+3+63, state IDLE, res_valid never asserted.
  - Next start clears timeout_err.
- **Spurious done**: fc_done pulsed during FEED with class 3, real done later with class 5:
  - res_class=5.
  - fc_ce count is still 16.
- **Reset mid-FEED**: global_rst_n low at addr 6:
  - All outputs 0 immediately (asynchronously).
  - After release, a new start runs a full 16-beat sequence from addr 0.
- **Back-to-back**: two starts separated by the minimum D+2 with res_ready tied high:
  - Two results, each run preceded by its own fc_rst, no overlap of fc_ce windows.
